tlb_unit: RTL and testbench
===========================

// Module: tlb_unit
// PURPOSE
// - Joint TLB and the responder end of CP0's TLB-op interface.
//   Services TLBP/TLBR/TLBWI/TLBWR using CP0 index/entry_hi/entry_lo0/1 values.
//   Returns index/entry_hi/entry_lo0/lo1 for CP0 to latch.
// - Also translates fetch and data addresses.
//   Raises refill/invalid/modified exceptions that CP0 consumes as i/d TLB exceptions.
// PARAMETERS
// - TLB_ENTRIES  16  number of entries; power of two, 4..32
// - IDX_W        4   log2(TLB_ENTRIES)
// PORTS
// - clk        in   1   clock
// - resetn     in   1   reset, asynchronous, active-low
// - req_valid  in   1   TLB op request from CP0
// - req_ready  out  1   unit can accept an op
// - req_op     in   2   0=TLBP 1=TLBR 2=TLBWI 3=TLBWR
// - cp0_index  in   32  CP0 Index; [IDX_W-1:0] used
// - cp0_ehi    in   32  EntryHi: vpn2[31:13], asid[7:0]
// - cp0_elo0   in   32  EntryLo0: pfn[25:6] c[5:3] d[2] v[1] g[0]
// - cp0_elo1   in   32  EntryLo1, same layout
// - wired      in   IDX_W  CP0 Wired value
// - wired_we   in   1   CP0 writes Wired this cycle
// - resp_valid out  1   one-cycle pulse: op complete, resp_* valid
// - resp_index out  32  TLBP result: [31]=P (miss), [IDX_W-1:0]=hit index
// - resp_ehi/resp_elo0/resp_elo1  out  32 each  TLBR read data
// - random     out  IDX_W  current Random value
// - i_vaddr    in   32  fetch address
// - i_paddr    out  32  fetch translation
// - i_exc      out  3   {refill, invalid, modified}
// - d_vaddr    in   32  data address
// - d_write    in   1   store access
// - d_paddr    out  32  data translation
// - d_exc      out  3   {refill, invalid, modified}
// BEHAVIOUR
// - Reset values:
//   - All entries cleared (V0=V1=0, G=0); state IDLE; random=TLB_ENTRIES-1.
//   - resp_valid=0, resp_*=0, *_paddr=0, *_exc=0.
//   - resetn asserted mid-op aborts the op; no resp_valid is produced.
// - Op FSM:
//   - States IDLE, LOOKUP, RESP. req_ready=1 only in IDLE.
//   - An op is accepted when req_valid && req_ready.
// - TLBP: IDLE->LOOKUP->RESP, latency 2.
//   - LOOKUP registers the compare of cp0_ehi.vpn2 vs each entry (match needs G or asid equal).
//   - RESP: resp_index = hit ? {0, lowest hit idx} : 32'h8000_0000.
// - TLBR: IDLE->RESP, latency 1, entry = cp0_index[IDX_W-1:0].
//   - resp_ehi = {vpn2, 5'b0, asid}.
//   - resp_eloN = {6'b0, pfnN, cN, dN, vN, G}.
// - TLBWI / TLBWR: entry written at the accept edge, then RESP.
//   - TLBWI uses cp0_index; TLBWR uses random.
//   - Stored G = elo0.g & elo1.g.
// - Random:
//   - Decrements every cycle; below wired or at 0, reloads TLB_ENTRIES-1.
//   - wired_we forces TLB_ENTRIES-1.
//   - Value is never < wired except the reload cycle.
// - Translation (i and d identical, independent), latency 1:
//   - Inputs sampled at edge N; outputs valid after edge N.
//   - kseg0/kseg1 (vaddr[31:30]==2'b10): paddr={3'b0,vaddr[28:0]}, exc=0.
//   - Mapped: compare vaddr[31:13] and current asid (cp0_ehi[7:0]) vs all entries.
//     Odd page selected by vaddr[12]. paddr={pfn,vaddr[11:0]}.
//   - Exception priority: miss->refill; !V->invalid; d_write && !D->modified (d only).
//   - On exception paddr=0.
//   - Multiple hits: lowest index wins.
// - Simultaneous write and lookup: the lookup in the write cycle sees old contents; the new entry is visible the next cycle.
// - TLBP after TLBWI with no gap sees the new entry.
// CONFIGURATION
// - TLB_IPORT_EN defined: i_* port translates as above.
// - TLB_IPORT_EN undefined: no i-side compare logic; i_paddr = {3'b0, i_vaddr[28:0]} registered, i_exc=0 (fetch unmapped).
// TESTING
// - Reset, then TLBP with ehi=32'h0040_0000 -> resp_valid 2 cycles after accept; resp_index=32'h8000_0000.
// - TLBWI idx3, ehi=32'h0040_0005, elo0=32'h0000_0046 (pfn1,V,D), elo1=0; TLBR idx3 ->
//   - resp_ehi=32'h0040_0005, resp_elo0=32'h0000_0046, G bit 0.
// - After that write, d_vaddr=32'h0040_0123 asid 5, d_write=1 -> d_paddr=32'h0000_1123, d_exc=0.
//   - With asid=6 -> d_exc=3'b100; with d_vaddr=32'h0040_1000 -> d_exc=3'b010.
// - Clear D, store to 32'h0040_0000 -> d_exc=3'b001; load -> d_exc=0.
// - wired=4 via wired_we, run 40 cycles -> random stays in 4..15, wraps 4->15.
//   - TLBWR writes the entry equal to random at the accept edge.
// - d_vaddr=32'hA000_1000 -> d_paddr=32'h0000_1000, d_exc=0.
//   - resetn low mid-TLBP -> no resp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/tlb_unit.sv
`default_nettype none
// ==== tlb_unit: joint TLB, CP0 TLB-op responder and i/d translation; TLB_IPORT_EN maps fetch. ====
// ==== Rev 1.0 ====
module tlb_unit #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      cp0_index,
    input  logic [31:0]      cp0_ehi,
    input  logic [31:0]      cp0_elo0,
    input  logic [31:0]      cp0_elo1,
    input  logic [IDX_W-1:0] wired,
    input  logic             wired_we,
    output logic             resp_valid,
    output logic [31:0]      resp_index,
    output logic [31:0]      resp_ehi,
    output logic [31:0]      resp_elo0,
    output logic [31:0]      resp_elo1,
    output logic [IDX_W-1:0] random,
    input  logic [31:0]      i_vaddr,
    output logic [31:0]      i_paddr,
    output logic [2:0]       i_exc,
    input  logic [31:0]      d_vaddr,
    input  logic             d_write,
    output logic [31:0]      d_paddr,
    output logic [2:0]       d_exc
);
    localparam logic [1:0] OP_TLBP = 2'd0;
    localparam logic [1:0] OP_TLBR = 2'd1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(TLB_ENTRIES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, RESP = 2'd2} state_t;
    state_t state, state_nxt;

    logic [18:0] e_vpn2 [TLB_ENTRIES];
    logic [7:0]  e_asid [TLB_ENTRIES];
    logic        e_g    [TLB_ENTRIES];
    logic [19:0] e_pfn  [TLB_ENTRIES][2];
    logic [2:0]  e_c    [TLB_ENTRIES][2];
    logic        e_d    [TLB_ENTRIES][2];
    logic        e_v    [TLB_ENTRIES][2];

    logic             accept;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W:0]   probe;

    // Returns {hit, index}; scanning downward leaves the lowest matching index.
    function automatic logic [IDX_W:0] find(input logic [18:0] vpn, input logic [7:0] asid);
        logic [IDX_W:0] res;
        res = '0;
        for (int k = TLB_ENTRIES - 1; k >= 0; k--)
            if (e_vpn2[k] == vpn && (e_g[k] || e_asid[k] == asid))
                res = {1'b1, k[IDX_W-1:0]};
        return res;
    endfunction

    // Returns {exc[2:0], paddr[31:0]} for one access against current contents.
    function automatic logic [34:0] xlate(input logic [31:0] va, input logic wr);
        logic [IDX_W:0]   f;
        logic [IDX_W-1:0] ix;
        logic             odd;
        logic [34:0]      res;
        f   = find(va[31:13], cp0_ehi[7:0]);
        ix  = f[IDX_W-1:0];
        odd = va[12];
        if (va[31:30] == 2'b10)        res = {3'b000, 3'b000, va[28:0]};
        else if (!f[IDX_W])            res = {3'b100, 32'h0};
        else if (!e_v[ix][odd])        res = {3'b010, 32'h0};
        else if (wr && !e_d[ix][odd])  res = {3'b001, 32'h0};
        else                           res = {3'b000, e_pfn[ix][odd], va[11:0]};
        return res;
    endfunction

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign wr_en      = accept && req_op[1];
    assign wr_idx     = req_op[0] ? random : cp0_index[IDX_W-1:0];
    assign rd_idx     = cp0_index[IDX_W-1:0];
    assign probe      = find(cp0_ehi[31:13], cp0_ehi[7:0]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = (req_op == OP_TLBP) ? LOOKUP : RESP;
            LOOKUP:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < TLB_ENTRIES; k++) begin
                e_vpn2[k] <= '0;
                e_asid[k] <= '0;
                e_g[k]    <= 1'b0;
                for (int p = 0; p < 2; p++) begin
                    e_pfn[k][p] <= '0;
                    e_c[k][p]   <= '0;
                    e_d[k][p]   <= 1'b0;
                    e_v[k][p]   <= 1'b0;
                end
            end
        end else if (wr_en) begin
            e_vpn2[wr_idx]   <= cp0_ehi[31:13];
            e_asid[wr_idx]   <= cp0_ehi[7:0];
            e_g[wr_idx]      <= cp0_elo0[0] & cp0_elo1[0];
            e_pfn[wr_idx][0] <= cp0_elo0[25:6];
            e_c[wr_idx][0]   <= cp0_elo0[5:3];
            e_d[wr_idx][0]   <= cp0_elo0[2];
            e_v[wr_idx][0]   <= cp0_elo0[1];
            e_pfn[wr_idx][1] <= cp0_elo1[25:6];
            e_c[wr_idx][1]   <= cp0_elo1[5:3];
            e_d[wr_idx][1]   <= cp0_elo1[2];
            e_v[wr_idx][1]   <= cp0_elo1[1];
        end
    end

    // Reaching wired (or zero, which is always <= wired) wraps back to the top entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                         random <= TOP_IDX;
        else if (wired_we || random <= wired) random <= TOP_IDX;
        else                                 random <= random - IDX_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_index <= '0;
            resp_ehi   <= '0;
            resp_elo0  <= '0;
            resp_elo1  <= '0;
        end else begin
            if (state == LOOKUP)
                resp_index <= probe[IDX_W] ? {{(32-IDX_W){1'b0}}, probe[IDX_W-1:0]} : 32'h8000_0000;
            if (accept && req_op == OP_TLBR) begin
                resp_ehi  <= {e_vpn2[rd_idx], 5'b0, e_asid[rd_idx]};
                resp_elo0 <= {6'b0, e_pfn[rd_idx][0], e_c[rd_idx][0], e_d[rd_idx][0], e_v[rd_idx][0], e_g[rd_idx]};
                resp_elo1 <= {6'b0, e_pfn[rd_idx][1], e_c[rd_idx][1], e_d[rd_idx][1], e_v[rd_idx][1], e_g[rd_idx]};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_paddr <= '0;
            d_exc   <= '0;
        end else begin
            {d_exc, d_paddr} <= xlate(d_vaddr, d_write);
        end
    end

`ifdef TLB_IPORT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_paddr <= '0;
            i_exc   <= '0;
        end else begin
            {i_exc, i_paddr} <= xlate(i_vaddr, 1'b0);
        end
    end
`else
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_paddr <= '0;
            i_exc   <= '0;
        end else begin
            i_paddr <= {3'b000, i_vaddr[28:0]};
            i_exc   <= 3'b000;
        end
    end

    logic unused_ivaddr;
    assign unused_ivaddr = &{1'b0, i_vaddr[31:29]};
`endif

    logic unused_bits;
    assign unused_bits = &{1'b0, cp0_index[31:IDX_W], cp0_ehi[12:8], cp0_elo0[31:26], cp0_elo1[31:26]};

endmodule
`default_nettype wire

// File: tb/tb_tlb_unit.sv
`default_nettype none
// tb_tlb_unit: directed stimulus for tlb_unit, checked each cycle against a behavioural TLB model.
module tb_tlb_unit;
    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'd0;
    logic [31:0]   cp0_index = '0, cp0_ehi = '0, cp0_elo0 = '0, cp0_elo1 = '0;
    logic [IW-1:0] wired = '0;
    logic          wired_we = 1'b0;
    logic          resp_valid;
    logic [31:0]   resp_index, resp_ehi, resp_elo0, resp_elo1;
    logic [IW-1:0] random;
    logic [31:0]   i_vaddr = '0, i_paddr;
    logic [2:0]    i_exc;
    logic [31:0]   d_vaddr = '0, d_paddr;
    logic          d_write = 1'b0;
    logic [2:0]    d_exc;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    tlb_unit #(.TLB_ENTRIES(N), .IDX_W(IW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .cp0_index(cp0_index), .cp0_ehi(cp0_ehi), .cp0_elo0(cp0_elo0), .cp0_elo1(cp0_elo1),
        .wired(wired), .wired_we(wired_we),
        .resp_valid(resp_valid), .resp_index(resp_index), .resp_ehi(resp_ehi),
        .resp_elo0(resp_elo0), .resp_elo1(resp_elo1), .random(random),
        .i_vaddr(i_vaddr), .i_paddr(i_paddr), .i_exc(i_exc),
        .d_vaddr(d_vaddr), .d_write(d_write), .d_paddr(d_paddr), .d_exc(d_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: entries kept as the raw CP0 words that were written.
    logic [31:0]   m_ehi [N];
    logic [31:0]   m_lo  [N][2];
    logic          m_g   [N];
    logic [IW-1:0] m_rand;
    logic          busy;
    logic [1:0]    bop;
    int            ecnt, resp_at, ready_at, m_idx, m_hit;
    logic          exp_ready, exp_rv;
    logic [31:0]   exp_ridx, exp_rehi, exp_relo0, exp_relo1, exp_dpa, exp_ipa;
    logic [2:0]    exp_dexc, exp_iexc;

    function automatic int m_find(input logic [31:0] ehi, input logic [7:0] asid);
        int hit;
        hit = -1;
        for (int k = N - 1; k >= 0; k--)
            if (m_ehi[k][31:13] == ehi[31:13] && (m_g[k] || m_ehi[k][7:0] == asid)) hit = k;
        return hit;
    endfunction

    function automatic logic [34:0] m_xlate(input logic [31:0] va, input logic wr, input logic [7:0] asid);
        int          k;
        logic [31:0] lo;
        if (va[31:30] == 2'b10) return {3'b000, 3'b000, va[28:0]};
        k = m_find(va, asid);
        if (k < 0) return {3'b100, 32'h0};
        lo = m_lo[k][va[12]];
        if (!lo[1]) return {3'b010, 32'h0};
        if (wr && !lo[2]) return {3'b001, 32'h0};
        return {3'b000, lo[25:6], va[11:0]};
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < N; k++) begin
                m_ehi[k] = '0; m_lo[k][0] = '0; m_lo[k][1] = '0; m_g[k] = 1'b0;
            end
            m_rand = IW'(N - 1); busy = 1'b0; ecnt = 0;
            exp_ready = 1'b1; exp_rv = 1'b0;
            exp_ridx = '0; exp_rehi = '0; exp_relo0 = '0; exp_relo1 = '0;
            exp_dpa = '0; exp_dexc = '0; exp_ipa = '0; exp_iexc = '0;
        end else begin
            ecnt++;
            {exp_dexc, exp_dpa} = m_xlate(d_vaddr, d_write, cp0_ehi[7:0]);
            exp_ipa  = {3'b000, i_vaddr[28:0]};
            exp_iexc = 3'b000;
            exp_rv   = 1'b0;
            if (!busy) begin
                if (req_valid) begin
                    busy     = 1'b1;
                    bop      = req_op;
                    resp_at  = (req_op == 2'd0) ? ecnt + 1 : ecnt;
                    ready_at = resp_at + 1;
                    m_idx    = (req_op == 2'd3) ? int'(m_rand) : int'(cp0_index[IW-1:0]);
                    if (req_op == 2'd1) begin
                        exp_rehi  = m_ehi[m_idx] & 32'hFFFF_E0FF;
                        exp_relo0 = (m_lo[m_idx][0] & 32'h03FF_FFFE) | {31'b0, m_g[m_idx]};
                        exp_relo1 = (m_lo[m_idx][1] & 32'h03FF_FFFE) | {31'b0, m_g[m_idx]};
                    end else if (req_op[1]) begin
                        m_ehi[m_idx]   = cp0_ehi;
                        m_lo[m_idx][0] = cp0_elo0;
                        m_lo[m_idx][1] = cp0_elo1;
                        m_g[m_idx]     = cp0_elo0[0] & cp0_elo1[0];
                    end
                end
            end else if (ecnt == ready_at) begin
                busy = 1'b0;
            end
            if (busy && ecnt == resp_at) begin
                exp_rv = 1'b1;
                if (bop == 2'd0) begin
                    m_hit    = m_find(cp0_ehi, cp0_ehi[7:0]);
                    exp_ridx = (m_hit < 0) ? 32'h8000_0000 : 32'(m_hit);
                end
            end
            m_rand    = (wired_we || m_rand <= wired) ? IW'(N - 1) : m_rand - IW'(1);
            exp_ready = !busy;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready",  {31'b0, req_ready},  {31'b0, exp_ready});
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_rv});
            chk("resp_index", resp_index, exp_ridx);
            chk("resp_ehi",   resp_ehi,   exp_rehi);
            chk("resp_elo0",  resp_elo0,  exp_relo0);
            chk("resp_elo1",  resp_elo1,  exp_relo1);
            chk("random",     {28'b0, random}, {28'b0, m_rand});
            chk("d_paddr",    d_paddr, exp_dpa);
            chk("d_exc",      {29'b0, d_exc}, {29'b0, exp_dexc});
            chk("i_paddr",    i_paddr, exp_ipa);
            chk("i_exc",      {29'b0, i_exc}, {29'b0, exp_iexc});
        end
    end

    // Issue one op; checks resp_valid rises exactly lat cycles after the accept edge.
    task automatic do_op(input logic [1:0] o, input int lat, output logic [IW-1:0] rnd_used);
        int n;
        req_op = o;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("op_accept", {31'b0, req_ready}, 32'd1);
        rnd_used = random;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int j = 1; j <= lat; j++) begin
            chk("op_latency", {31'b0, resp_valid}, {31'b0, (j == lat)});
            if (j < lat) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic d_probe(input logic [31:0] va, input logic wr, input logic [31:0] epa, input logic [2:0] eexc);
        d_vaddr = va;
        d_write = wr;
        i_vaddr = {va[15:0], va[31:16]};
        @(posedge clk); #1;
        chk("d_probe_paddr", d_paddr, epa);
        chk("d_probe_exc", {29'b0, d_exc}, {29'b0, eexc});
    endtask

    initial begin
        logic [IW-1:0] ru, prev;
        int wraps;
        wraps = 0;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        #1;
        chk("rst_random", {28'b0, random}, 32'd15);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_index", resp_index, 32'd0);
        chk("rst_d_paddr", d_paddr, 32'd0);
        chk("rst_d_exc", {29'b0, d_exc}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        cp0_ehi = 32'h0040_0000;
        do_op(2'd0, 2, ru);
        chk("tlbp_miss", resp_index, 32'h8000_0000);

        cp0_index = 32'd3; cp0_ehi = 32'h0040_0005; cp0_elo0 = 32'h0000_0046; cp0_elo1 = 32'h0;
        do_op(2'd2, 1, ru);
        do_op(2'd0, 2, ru);
        chk("tlbp_after_wi", resp_index, 32'd3);
        do_op(2'd1, 1, ru);
        chk("tlbr_ehi", resp_ehi, 32'h0040_0005);
        chk("tlbr_elo0", resp_elo0, 32'h0000_0046);
        chk("tlbr_elo1", resp_elo1, 32'h0000_0000);

        d_probe(32'h0040_0123, 1'b1, 32'h0000_1123, 3'b000);
        cp0_ehi = 32'h0040_0006;
        d_probe(32'h0040_0123, 1'b1, 32'h0, 3'b100);
        cp0_ehi = 32'h0040_0005;
        d_probe(32'h0040_1000, 1'b0, 32'h0, 3'b010);

        cp0_elo0 = 32'h0000_0042;
        do_op(2'd2, 1, ru);
        d_probe(32'h0040_0000, 1'b1, 32'h0, 3'b001);
        d_probe(32'h0040_0000, 1'b0, 32'h0000_1000, 3'b000);

        // Same VPN2 in entry 5: entry 3 must still win.
        cp0_index = 32'd5; cp0_elo0 = 32'h0000_0246;
        do_op(2'd2, 1, ru);
        d_probe(32'h0040_0123, 1'b0, 32'h0000_1123, 3'b000);
        do_op(2'd0, 2, ru);
        chk("tlbp_lowest", resp_index, 32'd3);

        d_probe(32'hA000_1000, 1'b1, 32'h0000_1000, 3'b000);
        d_probe(32'h8000_2345, 1'b0, 32'h0000_2345, 3'b000);

        wired = 4'd4; wired_we = 1'b1;
        @(posedge clk); #1;
        wired_we = 1'b0;
        chk("wired_we_reload", {28'b0, random}, 32'd15);
        for (int c = 0; c < 40; c++) begin
            prev = random;
            @(posedge clk); #1;
            chk("random_range", {31'b0, (random >= 4'd4)}, 32'd1);
            if (prev == 4'd4) begin
                chk("random_wrap", {28'b0, random}, 32'd15);
                wraps++;
            end
        end
        chk("random_wrapped_seen", {31'b0, (wraps > 0)}, 32'd1);

        cp0_ehi = 32'h0080_0007; cp0_elo0 = 32'h0000_0087; cp0_elo1 = 32'h0000_00C3;
        do_op(2'd3, 1, ru);
        chk("tlbwr_idx_ge_wired", {31'b0, (ru >= 4'd4)}, 32'd1);
        cp0_index = {28'b0, ru};
        do_op(2'd1, 1, ru);
        chk("tlbwr_ehi", resp_ehi, 32'h0080_0007);
        chk("tlbwr_elo0", resp_elo0, 32'h0000_0087);
        chk("tlbwr_elo1", resp_elo1, 32'h0000_00C3);
        cp0_ehi = 32'h0000_0005;
        d_probe(32'h0080_1ABC, 1'b0, 32'h0000_3ABC, 3'b000);
        d_probe(32'h0080_1ABC, 1'b1, 32'h0, 3'b001);
        d_probe(32'h0080_0010, 1'b1, 32'h0000_2010, 3'b000);

        cp0_ehi = 32'h0040_0005;
        req_op = 2'd0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        resetn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_no_resp_after", {31'b0, resp_valid}, 32'd0);
        end
        chk("ready_after_abort", {31'b0, req_ready}, 32'd1);
        cp0_index = 32'd3;
        do_op(2'd1, 1, ru);
        chk("cleared_entry", resp_elo0, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
